// File: rtl/turbo_pkg.sv
// Shared turbo-encoder definitions: FSM encoding, trellis constants and the RSC step function.
// Generators are stored as {D^0, D^1, D^2, D^3} coefficient vectors.
package turbo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } fsm_e;

  localparam int TAIL_LEN   = 3;
  localparam int NUM_STATES = 8;

  // g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (parity)
  localparam logic [3:0] G0_FB  = 4'b1011;
  localparam logic [3:0] G1_PAR = 4'b1101;

  // st = {s1,s2,s3}; low three generator bits are the s1..s3 taps. Returns {a, z}.
  function automatic logic [1:0] rsc_step(input logic u, input logic [2:0] st);
    logic a;
    logic z;
    a = u ^ (^(st & G0_FB[2:0]));
    z = a ^ (^(st & G1_PAR[2:0]));
    return {a, z};
  endfunction

endpackage

// File: rtl/rsc_trellis_core.sv
// 8-state RSC trellis register with parity logic; advances only on load_i.
// tail_i feeds back u = s2^s3 so the register shifts toward state 0.
module rsc_trellis_core
  import turbo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       tail_i,
  input  logic       u_i,
  output logic       sys_o,
  output logic       par_o
`ifdef RSC_TERM_CHECK_EN
  , output logic [2:0] state_nxt_o
`endif
);

  localparam int SW = $clog2(NUM_STATES);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          u_eff;
  logic [1:0]    az;

  always_comb begin
    u_eff   = tail_i ? (state_q[1] ^ state_q[0]) : u_i;
    az      = rsc_step(u_eff, state_q);
    sys_o   = u_eff;
    par_o   = az[0];
    state_d = load_i ? {az[1], state_q[2:1]} : state_q;
  end

`ifdef RSC_TERM_CHECK_EN
  assign state_nxt_o = state_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/rsc_term_encoder.sv
// RSC constituent encoder with 3-beat trellis termination; 1-cycle registered latency.
// Input stalls while the output beat is held or tail beats run; RSC_TERM_CHECK_EN adds term_err.
module rsc_term_encoder
  import turbo_pkg::*;
#(
  parameter int MAX_K = 6144,
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sys,
  output logic             out_par,
  output logic             out_tail,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_len,
  output logic             len_err
`ifdef RSC_TERM_CHECK_EN
  , output logic           term_err
`endif
);

  fsm_e             state_q, state_d;
  logic [1:0]       tail_cnt_q, tail_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sys_q, out_sys_d;
  logic             out_par_q, out_par_d;
  logic             out_tail_q, out_tail_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] blk_len_q, blk_len_d;
  logic             len_err_q, len_err_d;

  logic             load, accept, tail_load, tail_done, blk_end, at_max;
  logic [CNT_W-1:0] len_nxt;
  logic             core_sys, core_par;

`ifdef RSC_TERM_CHECK_EN
  logic       term_err_q, term_err_d;
  logic [2:0] core_state_nxt;
`endif

  rsc_trellis_core u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept | tail_load),
    .tail_i      (state_q == ST_TAIL),
    .u_i         (in_bit),
    .sys_o       (core_sys),
    .par_o       (core_par)
`ifdef RSC_TERM_CHECK_EN
    , .state_nxt_o (core_state_nxt)
`endif
  );

  always_comb begin
    load      = !out_valid_q || out_ready;
    in_ready  = (state_q != ST_TAIL) && load;
    accept    = in_valid && in_ready;
    tail_load = (state_q == ST_TAIL) && load;
    tail_done = tail_load && (tail_cnt_q == 2'(TAIL_LEN - 1));
    len_nxt   = (state_q == ST_IDLE) ? CNT_W'(1) : blk_len_q + 1'b1;
    // Hitting MAX_K closes the block exactly as in_last would.
    at_max    = (len_nxt == CNT_W'(MAX_K));
    blk_end   = in_last || at_max;
  end

  always_comb begin
    state_d     = state_q;
    tail_cnt_d  = tail_cnt_q;
    blk_len_d   = accept ? len_nxt : blk_len_q;
    len_err_d   = len_err_q | (accept && at_max && !in_last);
    out_valid_d = out_valid_q;
    out_sys_d   = out_sys_q;
    out_par_d   = out_par_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;

    if (load) begin
      out_valid_d = accept || tail_load;
      out_sys_d   = (accept || tail_load) && core_sys;
      out_par_d   = (accept || tail_load) && core_par;
      out_tail_d  = tail_load;
      out_last_d  = tail_done;
    end

    unique case (state_q)
      ST_IDLE: if (accept) state_d = blk_end ? ST_TAIL : ST_DATA;
      ST_DATA: if (accept && blk_end) state_d = ST_TAIL;
      ST_TAIL: begin
        if (tail_load) begin
          if (tail_done) begin
            state_d    = ST_IDLE;
            tail_cnt_d = 2'd0;
          end else begin
            tail_cnt_d = tail_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RSC_TERM_CHECK_EN
  assign term_err_d = term_err_q | (tail_done && (core_state_nxt != 3'd0));
  assign term_err   = term_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tail_cnt_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
      blk_len_q   <= '0;
      len_err_q   <= 1'b0;
`ifdef RSC_TERM_CHECK_EN
      term_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_sys_q   <= out_sys_d;
      out_par_q   <= out_par_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
      blk_len_q   <= blk_len_d;
      len_err_q   <= len_err_d;
`ifdef RSC_TERM_CHECK_EN
      term_err_q  <= term_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sys   = out_sys_q;
  assign out_par   = out_par_q;
  assign out_tail  = out_tail_q;
  assign out_last  = out_last_q;
  assign blk_len   = blk_len_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_rsc_term_encoder.sv
// Directed bench for rsc_term_encoder: cycle table plus backpressure and MAX_K sequences.
module tb_rsc_term_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, in_last, out_ready;
  logic        in_ready, out_valid, out_sys, out_par, out_tail, out_last, len_err;
  logic [12:0] blk_len;
  logic        k_in_valid, k_in_bit, k_in_last, k_out_ready;
  logic        k_in_ready, k_out_valid, k_out_sys, k_out_par, k_out_tail, k_out_last, k_len_err;
  logic [12:0] k_blk_len;
`ifdef RSC_TERM_CHECK_EN
  logic        term_err, k_term_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rsc_term_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sys(out_sys),
    .out_par(out_par), .out_tail(out_tail), .out_last(out_last), .blk_len(blk_len),
    .len_err(len_err)
`ifdef RSC_TERM_CHECK_EN
    , .term_err(term_err)
`endif
  );

  rsc_term_encoder #(.MAX_K(4), .CNT_W(13)) dut_k (
    .clk(clk), .rst(rst), .in_valid(k_in_valid), .in_ready(k_in_ready), .in_bit(k_in_bit),
    .in_last(k_in_last), .out_valid(k_out_valid), .out_ready(k_out_ready), .out_sys(k_out_sys),
    .out_par(k_out_par), .out_tail(k_out_tail), .out_last(k_out_last), .blk_len(k_blk_len),
    .len_err(k_len_err)
`ifdef RSC_TERM_CHECK_EN
    , .term_err(k_term_err)
`endif
  );

  typedef struct {
    logic rs, v, b, l, r;
    logic ca;
    logic rdy, ov, sy, pa, ta, la;
    int   bl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, v, b, l, r, ca, rdy, ov, sy, pa, ta, la, input int bl);
    vec_t t;
    t.rs = rs; t.v = v; t.b = b; t.l = l; t.r = r; t.ca = ca;
    t.rdy = rdy; t.ov = ov; t.sy = sy; t.pa = pa; t.ta = ta; t.la = la; t.bl = bl;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Beat code {sys,par,tail,last}
  logic [3:0] exp_bp[7];
  logic [3:0] exp_k[7];
  logic       blk_bp[4];
  logic       blk_k[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_bit = 0; in_last = 0; out_ready = 1;
    k_in_valid = 0; k_in_bit = 0; k_in_last = 0; k_out_ready = 1;

    // rs v b l r | all rdy ov sys par tail last | blk_len
    tbl.push_back(mk(0,1,1,0,1, 1,1,0,0,0,0,0, 0));
    tbl.push_back(mk(0,1,0,0,1, 0,1,1,1,1,0,0, 1));
    tbl.push_back(mk(0,1,1,0,1, 0,1,1,0,1,0,0, 2));
    tbl.push_back(mk(0,1,1,1,1, 0,1,1,1,0,0,0, 3));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,1,0,0, 4));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,0,1,0, 4));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,0,1,0, 4));
    tbl.push_back(mk(0,1,1,1,1, 0,1,1,0,0,1,1, 4));  // next block offered as last tail drains
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,1,0,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,1,1,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,0,1,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,1,1,1,1,1,1, 1));
    tbl.push_back(mk(0,1,1,1,1, 0,1,0,0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,1,0,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,1,1,0, 1));
    tbl.push_back(mk(1,0,0,0,1, 0,0,1,1,0,1,0, 1));  // reset during second tail beat
    tbl.push_back(mk(0,1,1,1,1, 1,1,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,1,0,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,1,1,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,1,0,1,0, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,1,1,1,1,1,1, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,1,0,0,0,0,0, 1));

    exp_bp = '{4'b1100, 4'b0100, 4'b1000, 4'b1100, 4'b0010, 4'b0010, 4'b0011};
    blk_bp = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_k  = '{4'b1100, 4'b1000, 4'b0000, 4'b1100, 4'b0010, 4'b0110, 4'b1111};
    blk_k  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rs; in_valid = tbl[i].v; in_bit = tbl[i].b;
      in_last = tbl[i].l; out_ready = tbl[i].r;
      #1;
      chk($sformatf("row%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
      chk($sformatf("row%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("row%0d_blk_len", i), int'(blk_len), tbl[i].bl);
      chk($sformatf("row%0d_len_err", i), int'(len_err), 0);
`ifdef RSC_TERM_CHECK_EN
      chk($sformatf("row%0d_term_err", i), int'(term_err), 0);
`endif
      if (tbl[i].ov || tbl[i].ca) begin
        chk($sformatf("row%0d_beat", i), int'({out_sys, out_par, out_tail, out_last}),
            int'({tbl[i].sy, tbl[i].pa, tbl[i].ta, tbl[i].la}));
      end
    end

    // Backpressure on [1,0,1,1]
    begin
      int idx = 0;
      int nb = 0;
      logic stall_prev = 1'b0;
      logic [3:0] prev = 4'd0;
      logic [3:0] cur;
      for (int c = 0; c < 300 && nb < 7; c++) begin
        @(negedge clk);
        in_valid = (idx < 4);
        in_bit   = (idx < 4) ? blk_bp[idx] : 1'b0;
        in_last  = (idx == 3);
        out_ready = (c == 2 || c == 3) ? 1'b0 : ($urandom_range(0, 2) != 0);
        #1;
        cur = {out_sys, out_par, out_tail, out_last};
        if (stall_prev) chk($sformatf("bp_hold_c%0d", c), int'(cur), int'(prev));
        if (out_valid && !out_ready) chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
        if (out_valid && out_ready) begin
          chk($sformatf("bp_beat%0d", nb), int'(cur), int'(exp_bp[nb]));
          nb++;
        end
        if (in_valid && in_ready) idx++;
        stall_prev = out_valid && !out_ready;
        prev = cur;
      end
      chk("bp_beats_seen", nb, 7);
      chk("bp_blk_len", int'(blk_len), 4);
      @(negedge clk);
      in_valid = 0; in_last = 0; out_ready = 1;
    end

    // MAX_K=4 with five bits and no in_last
    begin
      int kidx = 0;
      int nb = 0;
      logic seen_last = 1'b0;
      for (int c = 0; c < 60 && kidx < 5; c++) begin
        @(negedge clk);
        k_in_valid = 1'b1; k_in_bit = blk_k[kidx]; k_in_last = 1'b0; k_out_ready = 1'b1;
        #1;
        if (k_out_valid) begin
          if (nb < 7) chk($sformatf("k_beat%0d", nb),
                          int'({k_out_sys, k_out_par, k_out_tail, k_out_last}), int'(exp_k[nb]));
          if (k_out_last) begin
            seen_last = 1'b1;
            chk("k_acc_before_last", kidx, 4);
            chk("k_blk_len", int'(k_blk_len), 4);
            chk("k_len_err", int'(k_len_err), 1);
          end
          nb++;
        end
        if (k_in_valid && k_in_ready) begin
          if (kidx == 4) chk("k_5th_after_last", int'(seen_last), 1);
          kidx++;
        end
      end
      chk("k_all_accepted", kidx, 5);
      chk("k_beats_before_5th", nb, 7);
      @(negedge clk);
      k_in_valid = 1'b0;
      #1;
      chk("k_next_beat", int'({k_out_valid, k_out_sys, k_out_par, k_out_tail, k_out_last}), 5'b11100);
      chk("k_next_blk_len", int'(k_blk_len), 1);
      chk("k_len_err_sticky", int'(k_len_err), 1);
`ifdef RSC_TERM_CHECK_EN
      chk("k_term_err", int'(k_term_err), 0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
